// File: rtl/bcd_counter_display_pkg.sv
// Shared constants for the BCD counter/display slice: digit count, active-low
// 7-segment glyphs and the all-off anode pattern.
package bcd_counter_display_pkg;

  localparam int DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_OFF = 4'b1111;

  // Out-of-range nibbles cannot occur, but map them to blank rather than garbage.
  function automatic logic [6:0] glyph(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_counter_display_bcd_digit.sv
// One decimal digit of the counter: combinational +1/-1 with carry and borrow
// out. The parent chains four of these and owns the registers.
module bcd_digit (
  input  logic [3:0] value,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] next_value,
  output logic       carry,
  output logic       borrow
);

  always_comb begin
    next_value = value;
    carry      = 1'b0;
    borrow     = 1'b0;
    if (inc) begin
      if (value >= 4'd9) begin
        next_value = 4'd0;
        carry      = 1'b1;
      end else begin
        next_value = value + 4'd1;
      end
    end else if (dec) begin
      if (value == 4'd0) begin
        next_value = 4'd9;
        borrow     = 1'b1;
      end else begin
        next_value = value - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_counter_display.sv
// Four-digit BCD up/down event counter with a multiplexed common-anode
// 7-segment scan driver refreshed from the shared 1 ms strobe.
module bcd_counter_display
  import bcd_counter_display_pkg::*;
#(
  parameter int REFRESH_MS = 4,
  parameter bit BLANK_LZ   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce1ms,
  input  logic        UP,
  input  logic        DOWN,
  input  logic        CLR,
  output logic [15:0] COUNT,
  output logic        WRAP,
  output logic [6:0]  SEG,
  output logic [3:0]  AN,
  output logic        DP
);

  localparam logic [7:0] TICK_LAST = 8'(REFRESH_MS - 1);

  logic up_q, down_q, clr_q;
  logic up_edge, down_edge, clr_edge;
  logic inc_req, dec_req;

  assign up_edge   = UP & ~up_q;
  assign down_edge = DOWN & ~down_q;
  assign clr_edge  = CLR & ~clr_q;

  // Clear wins outright; simultaneous up and down cancel each other.
  assign inc_req = up_edge & ~down_edge & ~clr_edge;
  assign dec_req = down_edge & ~up_edge & ~clr_edge;

  logic [DIGITS-1:0] carry, borrow;
  logic [DIGITS-1:0] inc_in, dec_in;
  logic [15:0]       next_count;

  assign inc_in = {carry[DIGITS-2:0], inc_req};
  assign dec_in = {borrow[DIGITS-2:0], dec_req};

  genvar i;
  generate
    for (i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit u_digit (
        .value      (COUNT[4*i +: 4]),
        .inc        (inc_in[i]),
        .dec        (dec_in[i]),
        .next_value (next_count[4*i +: 4]),
        .carry      (carry[i]),
        .borrow     (borrow[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_q   <= 1'b0;
      down_q <= 1'b0;
      clr_q  <= 1'b0;
      COUNT  <= 16'h0000;
      WRAP   <= 1'b0;
    end else begin
      up_q   <= UP;
      down_q <= DOWN;
      clr_q  <= CLR;
      if (clr_edge) begin
        COUNT <= 16'h0000;
        WRAP  <= 1'b0;
      end else begin
        COUNT <= next_count;
        WRAP  <= carry[DIGITS-1] | borrow[DIGITS-1];
      end
    end
  end

  logic [1:0] idx;
  logic [1:0] next_idx;
  logic [7:0] tcnt;
  logic [3:0] lz;
  logic [3:0] load_digit;
  logic [6:0] load_seg;

  // lz[i] is set when digits i..3 are all zero; digit 0 is never blanked.
  assign lz[3] = (COUNT[15:12] == 4'd0);
  assign lz[2] = lz[3] & (COUNT[11:8] == 4'd0);
  assign lz[1] = lz[2] & (COUNT[7:4] == 4'd0);
  assign lz[0] = 1'b0;

  assign next_idx   = idx + 2'd1;
  assign load_digit = COUNT[4*next_idx +: 4];
  assign load_seg   = (BLANK_LZ && lz[next_idx]) ? SEG_BLANK : glyph(load_digit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= 2'd3;
      tcnt <= 8'd0;
      AN   <= AN_OFF;
      SEG  <= SEG_BLANK;
      DP   <= 1'b1;
    end else begin
      DP <= 1'b1;
      if (ce1ms) begin
        if (tcnt == TICK_LAST) begin
          tcnt <= 8'd0;
          idx  <= next_idx;
          AN   <= ~(4'b0001 << next_idx);
          SEG  <= load_seg;
        end else begin
          tcnt <= tcnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_counter_display.sv
// Directed and randomized checks of the BCD counter, wrap pulse, scan timing
// and leading-zero blanking.
module tb_bcd_counter_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce1ms;
  logic        UP, DOWN, CLR;
  logic [15:0] COUNT;
  logic        WRAP;
  logic [6:0]  SEG;
  logic [3:0]  AN;
  logic        DP;

  int checks = 0;
  int failures = 0;

  bcd_counter_display #(.REFRESH_MS(2), .BLANK_LZ(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ce1ms (ce1ms),
    .UP    (UP),
    .DOWN  (DOWN),
    .CLR   (CLR),
    .COUNT (COUNT),
    .WRAP  (WRAP),
    .SEG   (SEG),
    .AN    (AN),
    .DP    (DP)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one pulse of len cycles starting at a falling edge, then one idle cycle.
  task automatic applyStimulus(input logic u, input logic d, input logic c, input int len,
                               output logic [15:0] cnt, output logic wrap_first,
                               output logic wrap_after);
    UP = u; DOWN = d; CLR = c;
    @(negedge clk);
    cnt = COUNT;
    wrap_first = WRAP;
    for (int k = 1; k < len; k++) @(negedge clk);
    UP = 1'b0; DOWN = 1'b0; CLR = 1'b0;
    @(negedge clk);
    wrap_after = WRAP;
  endtask

  task automatic strobe();
    ce1ms = 1'b1;
    @(negedge clk);
    ce1ms = 1'b0;
  endtask

  task automatic goTo(input int value);
    logic [15:0] c;
    logic w1, w2;
    applyStimulus(1'b0, 1'b0, 1'b1, 1, c, w1, w2);
    for (int k = 0; k < value; k++) applyStimulus(1'b1, 1'b0, 1'b0, 1, c, w1, w2);
  endtask

  function automatic logic [15:0] toBcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic nibblesLegal(input logic [15:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v[11:8] <= 4'd9) && (v[15:12] <= 4'd9);
  endfunction

  initial begin
    logic [15:0] cnt;
    logic        wf, wa;
    logic [3:0]  prev_an;
    bit          found;
    int          model;
    logic        ru, rd, rc, exp_wrap;

    rst_n = 1'b0; ce1ms = 1'b0; UP = 1'b0; DOWN = 1'b0; CLR = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_count", COUNT, 16'h0000);
    checkOutput("reset_wrap", WRAP, 1'b0);
    checkOutput("reset_an", AN, 4'b1111);
    checkOutput("reset_seg", SEG, 7'b1111111);
    checkOutput("reset_dp", DP, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    strobe();
    checkOutput("first_strobe_an", AN, 4'b1111);
    strobe();
    checkOutput("first_load_an", AN, 4'b1110);
    checkOutput("first_load_seg", SEG, 7'b1000000);

    // Input held high through reset release counts once.
    UP = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("held_up_count", COUNT, 16'h0001);
    UP = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("held_up_once", COUNT, 16'h0001);

    // Asynchronous reset in the middle of a scan.
    goTo(123);
    checkOutput("goto_123", COUNT, 16'h0123);
    repeat (3) strobe();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_count", COUNT, 16'h0000);
    checkOutput("async_rst_an", AN, 4'b1111);
    checkOutput("async_rst_seg", SEG, 7'b1111111);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    strobe();
    checkOutput("rst_strobe1_an", AN, 4'b1111);
    strobe();
    checkOutput("rst_strobe2_an", AN, 4'b1110);
    checkOutput("rst_strobe2_seg", SEG, 7'b1000000);

    // Carry ripple and pulse-width independence.
    goTo(99);
    applyStimulus(1'b1, 1'b0, 1'b0, 1, cnt, wf, wa);
    checkOutput("carry_count", cnt, 16'h0100);
    checkOutput("carry_wrap", wf, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 5, cnt, wf, wa);
    checkOutput("wide_up_first", cnt, 16'h0101);
    checkOutput("wide_up_final", COUNT, 16'h0101);

    // Wrap in both directions.
    goTo(0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1, cnt, wf, wa);
    checkOutput("wrap_down_count", cnt, 16'h9999);
    checkOutput("wrap_down_pulse", wf, 1'b1);
    checkOutput("wrap_down_after", wa, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1, cnt, wf, wa);
    checkOutput("wrap_up_count", cnt, 16'h0000);
    checkOutput("wrap_up_pulse", wf, 1'b1);
    checkOutput("wrap_up_after", wa, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1, cnt, wf, wa);
    applyStimulus(1'b0, 1'b0, 1'b1, 1, cnt, wf, wa);
    checkOutput("clr_at_9999_count", cnt, 16'h0000);
    checkOutput("clr_no_wrap", wf, 1'b0);

    // Simultaneous events.
    goTo(500);
    applyStimulus(1'b1, 1'b1, 1'b0, 1, cnt, wf, wa);
    checkOutput("up_down_cancel", cnt, 16'h0500);
    checkOutput("up_down_no_wrap", wf, 1'b0);
    goTo(42);
    applyStimulus(1'b1, 1'b0, 1'b1, 1, cnt, wf, wa);
    checkOutput("clr_up_count", cnt, 16'h0000);
    checkOutput("clr_up_no_wrap", wf, 1'b0);

    // Scan order, dwell time and leading-zero blanking at 0x0007.
    goTo(7);
    repeat (8) strobe();
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      prev_an = AN;
      strobe();
      if (AN == 4'b1110 && prev_an != 4'b1110) found = 1'b1;
    end
    checkOutput("scan_sync", found, 1'b1);
    checkOutput("scan_d0_an", AN, 4'b1110);
    checkOutput("scan_d0_seg", SEG, 7'b1111000);
    strobe();
    checkOutput("scan_d0_dwell", AN, 4'b1110);
    strobe();
    checkOutput("scan_d1_an", AN, 4'b1101);
    checkOutput("scan_d1_seg", SEG, 7'b1111111);
    repeat (2) strobe();
    checkOutput("scan_d2_an", AN, 4'b1011);
    checkOutput("scan_d2_seg", SEG, 7'b1111111);
    repeat (2) strobe();
    checkOutput("scan_d3_an", AN, 4'b0111);
    checkOutput("scan_d3_seg", SEG, 7'b1111111);
    repeat (2) strobe();
    checkOutput("scan_wrap_an", AN, 4'b1110);
    checkOutput("scan_wrap_seg", SEG, 7'b1111000);

    // Random pulses against a decimal integer model.
    applyStimulus(1'b0, 1'b0, 1'b1, 1, cnt, wf, wa);
    model = 0;
    for (int n = 0; n < 20000; n++) begin
      ru = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      rc = ($urandom_range(0, 19) == 0);
      exp_wrap = 1'b0;
      if (rc) model = 0;
      else if (ru && !rd) begin
        if (model == 9999) begin model = 0; exp_wrap = 1'b1; end
        else model = model + 1;
      end else if (rd && !ru) begin
        if (model == 0) begin model = 9999; exp_wrap = 1'b1; end
        else model = model - 1;
      end
      applyStimulus(ru, rd, rc, 1, cnt, wf, wa);
      checkOutput("rand_count", cnt, toBcd(model));
      checkOutput("rand_wrap", wf, exp_wrap);
      checkOutput("rand_bcd_legal", nibblesLegal(cnt), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
